// File: rtl/sig16b_to_double_pkg.sv
// Shared definitions for the sign-magnitude <-> IEEE-754 binary64 converters.
// Both conversion directions (sig16b_to_double and double_to_sig16b) import
// this package, so field widths, the exponent bias and the FSM encoding live
// in one place.
package sig16b_to_double_pkg;

    localparam int DOUBLE_W = 64;
    localparam int EXP_W    = 11;
    localparam int FRAC_W   = 52;
    localparam int EXP_BIAS = 1023;
    localparam int SIG_W    = 16;

    // Iterative converter FSM: wait for a sample, normalise, hold the result.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        NORM = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/sig16b_to_double.sv
// sig16b_to_double
// Converts a 16-bit sign-magnitude integer sample into an exact IEEE-754
// binary64 value. The magnitude is normalised one bit per cycle, so latency
// depends on the leading-one position (2..16 cycles, 1 for zero).
//
// Ports
//   clk        clock, rising edge
//   rst        asynchronous reset, active low
//   sig16b     sample: [15] sign, [14:0] unsigned magnitude
//   in_valid   sig16b holds a sample
//   in_ready   block accepts a sample this cycle (high only in IDLE)
//   double     binary64 result, valid while out_valid is high
//   out_valid  result available (high only in DONE)
//   out_ready  consumer takes the result this cycle
module sig16b_to_double #(
    parameter int SIG_W    = 16,
    parameter int EXP_BIAS = 1023
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [SIG_W-1:0]     sig16b,
    input  logic                 in_valid,
    output logic                 in_ready,
    output logic [63:0]          double,
    output logic                 out_valid,
    input  logic                 out_ready
);

    import sig16b_to_double_pkg::*;

    localparam int MAG_W  = SIG_W - 1;          // magnitude bits
    localparam int E_W    = $clog2(MAG_W);      // holds 0..MAG_W-1
    localparam int PAD_W  = FRAC_W - (MAG_W - 1);
    localparam logic [E_W-1:0] E_INIT = E_W'(MAG_W - 1);

    state_t                state_q, state_d;
    logic                  s_q;
    logic [MAG_W-1:0]      m_q;
    logic [E_W-1:0]        e_q;
    logic [DOUBLE_W-1:0]   dbl_q;

    logic [MAG_W-1:0]      mag_in;
    logic                  accept;
    logic [EXP_W-1:0]      exp_field;

    assign mag_in    = sig16b[MAG_W-1:0];
    assign accept    = in_valid && (state_q == IDLE);
    // E never exceeds MAG_W-1, so the biased exponent stays in 1023..1037.
    assign exp_field = EXP_W'(EXP_BIAS) + EXP_W'(e_q);

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == DONE);
    assign double    = dbl_q;

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (in_valid) state_d = (mag_in == '0) ? DONE : NORM;
            NORM: if (m_q[MAG_W-1]) state_d = DONE;
            DONE: if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ---------------- normaliser / pack ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s_q   <= 1'b0;
            m_q   <= '0;
            e_q   <= '0;
            dbl_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        s_q <= sig16b[SIG_W-1];
                        m_q <= mag_in;
                        e_q <= E_INIT;
                        // Zero bypasses normalisation; the sign is kept so
                        // 0x8000 becomes -0.0.
                        if (mag_in == '0)
                            dbl_q <= {sig16b[SIG_W-1], {(DOUBLE_W-1){1'b0}}};
                    end
                end
                NORM: begin
                    if (m_q[MAG_W-1]) begin
                        // Leading one is implicit; remaining bits are exact.
                        dbl_q <= {s_q, exp_field, m_q[MAG_W-2:0], {PAD_W{1'b0}}};
                    end else begin
                        m_q <= m_q << 1;
                        e_q <= e_q - 1'b1;
                    end
                end
                default: ;  // DONE holds the result
            endcase
        end
    end

endmodule

// File: tb/tb_sig16b_to_double.sv
module tb_sig16b_to_double;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] sig16b;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] dbl;
    logic        out_valid;
    logic        out_ready;

    int n_tests = 0;
    int n_fail  = 0;

    logic [63:0] sb[$];
    logic [15:0] stim[$];

    always #5 clk = ~clk;

    sig16b_to_double #(.SIG_W(16), .EXP_BIAS(1023)) dut (
        .clk      (clk),
        .rst      (rst),
        .sig16b   (sig16b),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .double   (dbl),
        .out_valid(out_valid),
        .out_ready(out_ready)
    );

    // Reference: let the simulator's real arithmetic produce the bits.
    function automatic logic [63:0] ref_bits(input logic [15:0] x);
        real r;
        if (x[14:0] == 15'd0) return {x[15], 63'd0};
        r = real'(x[14:0]);
        if (x[15]) r = -r;
        return $realtobits(r);
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    // One sample with out_ready high; checks result, latency and release.
    task automatic directed(input logic [15:0] x, input logic [63:0] exp,
                            input int lat, input string tag);
        int k;
        bit seen;
        @(negedge clk);
        check({tag, ".in_ready"}, 64'(in_ready), 64'd1);
        sig16b = x; in_valid = 1'b1; out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0; sig16b = 16'($urandom);
        k = 1; seen = 1'b0;
        while (!seen && k <= 40) begin
            if (out_valid) seen = 1'b1;
            else begin
                @(negedge clk);
                k++;
            end
        end
        check({tag, ".lat"}, seen ? 64'(k) : 64'hFFFF, 64'(lat));
        check({tag, ".dbl"}, dbl, exp);
        check({tag, ".busy"}, 64'(in_ready), 64'd0);
        @(posedge clk);
        @(negedge clk);
        check({tag, ".ov_drop"}, 64'(out_valid), 64'd0);
        check({tag, ".idle"}, 64'(in_ready), 64'd1);
    endtask

    initial begin
        int cyc, n_out, idx, quiet_hits;
        bit stall_prev;
        logic [63:0] prev_dbl;

        // ---- reset state ----
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sig16b = 16'h0;
        #12;
        check("rst.out_valid", 64'(out_valid), 64'd0);
        check("rst.in_ready", 64'(in_ready), 64'd1);
        check("rst.double", dbl, 64'd0);
        @(negedge clk);
        rst = 1'b1;

        // ---- directed conversions ----
        directed(16'h0003, 64'h4008000000000000, 15, "p1_3");
        directed(16'hFFFF, 64'hC0DFFFC000000000, 2,  "neg_max");
        directed(16'h0001, 64'h3FF0000000000000, 16, "one");
        directed(16'h0000, 64'h0000000000000000, 1,  "zero");
        directed(16'h8000, 64'h8000000000000000, 1,  "neg_zero");
        directed(16'h7FFF, 64'h40DFFFC000000000, 2,  "pos_max");

        // ---- back-pressure: 0x4000 held 5 cycles ----
        @(negedge clk);
        sig16b = 16'h4000; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        check("hold.norm", 64'(out_valid), 64'd0);
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            check("hold.ov", 64'(out_valid), 64'd1);
            check("hold.ir", 64'(in_ready), 64'd0);
            check("hold.dbl", dbl, 64'h40D0000000000000);
            @(negedge clk);
        end
        out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("hold.release_ir", 64'(in_ready), 64'd1);
        check("hold.release_ov", 64'(out_valid), 64'd0);
        check("hold.idle_keep", dbl, 64'h40D0000000000000);

        // ---- reset mid-NORM aborts the conversion ----
        sig16b = 16'h0001; in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (4) @(negedge clk);
        rst = 1'b0;
        #1;
        check("abort.ov", 64'(out_valid), 64'd0);
        check("abort.dbl", dbl, 64'd0);
        check("abort.ir", 64'(in_ready), 64'd1);
        @(negedge clk);
        rst = 1'b1;
        quiet_hits = 0;
        repeat (20) begin
            @(negedge clk);
            if (out_valid) quiet_hits++;
        end
        check("abort.no_ov", 64'(quiet_hits), 64'd0);
        directed(16'h0002, 64'h4000000000000000, 15, "after_abort");

        // ---- random-handshake stream ----
        stim.push_back(16'h0000);
        stim.push_back(16'h8000);
        for (int p = 0; p < 15; p++) begin
            stim.push_back(16'(1 << p));
            stim.push_back(16'((2 << p) - 1));
            stim.push_back(16'h8000 | 16'(1 << p));
            stim.push_back(16'h8000 | 16'((2 << p) - 1));
        end
        for (int v = 0; v < 65536; v += 37) stim.push_back(16'(v));

        idx = 0; n_out = 0; cyc = 0; stall_prev = 1'b0; prev_dbl = '0;
        while ((idx < stim.size() || sb.size() > 0) && cyc < 60000) begin
            @(negedge clk);
            cyc++;
            if (stall_prev) begin
                check("stream.hold_ov", 64'(out_valid), 64'd1);
                check("stream.hold_dbl", dbl, prev_dbl);
            end
            in_valid  = (idx < stim.size()) && ($urandom_range(0, 3) != 0);
            sig16b    = in_valid ? stim[idx] : 16'($urandom);
            out_ready = ($urandom_range(0, 2) != 0);
            if (in_valid && in_ready) begin
                sb.push_back(ref_bits(stim[idx]));
                idx++;
            end
            if (out_valid && out_ready) begin
                n_out++;
                if (sb.size() > 0) check("stream.dbl", dbl, sb.pop_front());
            end
            stall_prev = out_valid && !out_ready;
            prev_dbl   = dbl;
        end
        in_valid = 1'b0;
        check("stream.count", 64'(n_out), 64'(stim.size()));
        check("stream.drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
